// File: rtl/sysid_pkg.sv
// Shared definitions for the system-ID checker: FSM encoding, default expected
// constants and the terminal-value helper for the wait counter.
package sysid_pkg;

    typedef enum logic [1:0] {
        RD_ID = 2'd0,
        RD_TS = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [31:0] DEFAULT_EXPECTED_ID        = 32'd0;
    localparam logic [31:0] DEFAULT_EXPECTED_TIMESTAMP = 32'd1720034865;
    localparam int unsigned CNT_W                      = 32;

    // The counter is cleared to zero on state entry and decrements every cycle,
    // so the last of 'cycles' cycles is reached when it reads -(cycles-1).
    function automatic logic [CNT_W-1:0] terminal_of(input logic [CNT_W-1:0] cycles);
        return {CNT_W{1'b0}} - (cycles - {{(CNT_W-1){1'b0}}, 1'b1});
    endfunction

endpackage

// File: rtl/sysid_wait_counter.sv
// Loadable down-counter; tc_o flags that the count has reached the requested
// terminal value.
module sysid_wait_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic [W-1:0] term_i,
    output logic         tc_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: load on request, otherwise step down by one.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else begin
            count_d = count_q - {{(W-1){1'b0}}, 1'b1};
        end
    end

    // Count register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= {W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == term_i);

endmodule

// File: rtl/sysid_checker.sv
// Reads the system-ID slave at address 0 then 1, compares both words against
// the expected constants and optionally re-runs the check periodically.
module sysid_checker
    import sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID        = DEFAULT_EXPECTED_ID,
    parameter logic [31:0] EXPECTED_TIMESTAMP = DEFAULT_EXPECTED_TIMESTAMP,
    parameter int unsigned READ_LATENCY       = 1,
    parameter int unsigned RECHECK_PERIOD     = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        sysid_address,
    input  logic [31:0] sysid_readdata,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic        mismatch_seen
);

    localparam logic [CNT_W-1:0] LAT_TERM  = terminal_of(READ_LATENCY);
    localparam logic [CNT_W-1:0] PER_TERM  = terminal_of(RECHECK_PERIOD);
    localparam logic             RECHECK_EN = (RECHECK_PERIOD != 0);

    state_e      state_q, state_d;
    logic [31:0] id_value_q, id_value_d;
    logic [31:0] ts_value_q, ts_value_d;
    logic        id_ok_q, id_ok_d;
    logic        ts_ok_q, ts_ok_d;
    logic        mismatch_q, mismatch_d;
    logic [CNT_W-1:0] term_s;
    logic        tc_s;
    logic        load_s;

    // The same counter times the read latency and, in DONE, the recheck period;
    // it restarts from zero whenever the state changes.
    sysid_wait_counter #(.W(CNT_W)) u_wait (
        .clock      (clock),
        .reset      (reset),
        .load_i     (load_s),
        .load_val_i ({CNT_W{1'b0}}),
        .term_i     (term_s),
        .tc_o       (tc_s)
    );

    // Next-state, capture and compare logic.
    always_comb begin
        state_d    = state_q;
        id_value_d = id_value_q;
        ts_value_d = ts_value_q;
        id_ok_d    = id_ok_q;
        ts_ok_d    = ts_ok_q;
        mismatch_d = mismatch_q;
        term_s     = LAT_TERM;
        case (state_q)
            RD_ID: begin
                if (tc_s) begin
                    state_d    = RD_TS;
                    id_value_d = sysid_readdata;
                end else begin
                    state_d = RD_ID;
                end
            end
            RD_TS: begin
                if (tc_s) begin
                    state_d    = DONE;
                    ts_value_d = sysid_readdata;
                    id_ok_d    = (id_value_q == EXPECTED_ID);
                    ts_ok_d    = (sysid_readdata == EXPECTED_TIMESTAMP);
                    if ((id_value_q != EXPECTED_ID) || (sysid_readdata != EXPECTED_TIMESTAMP)) begin
                        mismatch_d = 1'b1;
                    end else begin
                        mismatch_d = mismatch_q;
                    end
                end else begin
                    state_d = RD_TS;
                end
            end
            DONE: begin
                term_s = PER_TERM;
                if (start || (RECHECK_EN && tc_s)) begin
                    state_d = RD_ID;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = RD_ID;
            end
        endcase
        load_s = (state_d != state_q);
    end

    // State and result registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= RD_ID;
            id_value_q <= 32'd0;
            ts_value_q <= 32'd0;
            id_ok_q    <= 1'b0;
            ts_ok_q    <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            id_value_q <= id_value_d;
            ts_value_q <= ts_value_d;
            id_ok_q    <= id_ok_d;
            ts_ok_q    <= ts_ok_d;
            mismatch_q <= mismatch_d;
        end
    end

    assign sysid_address = (state_q != RD_ID);
    assign busy          = (state_q == RD_ID) || (state_q == RD_TS);
    assign done          = (state_q == DONE);
    assign id_ok         = id_ok_q;
    assign ts_ok         = ts_ok_q;
    assign id_value      = id_value_q;
    assign ts_value      = ts_value_q;
    assign mismatch_seen = mismatch_q;

endmodule
